// File: rtl/sim_av_out.sv
// Audio/video output stage for the simulation top: pixel clock-enable
// generation, colour widening with blanking, registered syncs, beam position
// tracking, active width/height measurement and audio widening.
module sim_av_out #(
  parameter int COLOR_BITS   = 6,
  parameter int AUDIO_BITS   = 8,
  parameter int AUDIO_SIGNED = 0,
  parameter int CE_EXT       = 1,
  parameter int CE_DIV       = 4,
  parameter int SYNC_POL     = 0
) (
  input  logic                  clk_48,
  input  logic                  reset,
  input  logic                  clk_ref,
  input  logic [COLOR_BITS-1:0] r_in,
  input  logic [COLOR_BITS-1:0] g_in,
  input  logic [COLOR_BITS-1:0] b_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  de_in,
  input  logic [AUDIO_BITS-1:0] audio_in,
  output logic                  ce_pix,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic [11:0]           pix_x,
  output logic [11:0]           pix_y,
  output logic [15:0]           frame_cnt,
  output logic                  frame_start,
  output logic [11:0]           line_width,
  output logic [11:0]           frame_height,
  output logic [15:0]           audio_out
);

  localparam logic [3:0]  DIV_LAST = 4'(CE_DIV - 1);
  localparam logic        POL      = 1'(SYNC_POL);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  // Replicate the MSBs into the vacated LSBs; COLOR_BITS >= 4 means one
  // wrap of the modulo is always enough, and COLOR_BITS = 8 passes through.
  function automatic logic [7:0] expand_c(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
    return e;
  endfunction

  // Unsigned audio repeats its MSBs; signed audio is zero-padded so the
  // sign bit stays at the top.
  function automatic logic [15:0] widen_a(input logic [AUDIO_BITS-1:0] a);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (AUDIO_SIGNED == 0 || i < AUDIO_BITS) w[15-i] = a[AUDIO_BITS-1-(i % AUDIO_BITS)];
    end
    return w;
  endfunction

  logic        ref_q, ref_d;
  logic [3:0]  div_q, div_d;
  logic        ce_q, ce_d;
  logic [7:0]  vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic        vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_de_q, vga_de_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic        line_had_de_q, line_had_de_d;
  logic [11:0] line_width_q, line_width_d, frame_height_q, frame_height_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] audio_q, audio_d;
  logic        hs_edge, vs_edge;

  // Pixel enable: falling edge of the reference clock, or divider terminal count.
  always_comb begin
    ref_d = clk_ref;
    div_d = div_q;
    ce_d  = 1'b0;
    if (CE_EXT != 0) begin
      ce_d = ref_q & ~clk_ref;
    end else begin
      ce_d  = (div_q == DIV_LAST);
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
  end

  // The registered syncs double as the previous-sample history for edge
  // detection; both only move on ce_pix.
  assign hs_edge = ce_q && (vga_hs_q != POL) && (hs_in == POL);
  assign vs_edge = ce_q && (vga_vs_q != POL) && (vs_in == POL);

  // Video sampling and geometry tracking; hs is resolved before vs so a
  // coincident edge still counts the line that just ended.
  always_comb begin
    vga_r_d        = vga_r_q;
    vga_g_d        = vga_g_q;
    vga_b_d        = vga_b_q;
    vga_hs_d       = vga_hs_q;
    vga_vs_d       = vga_vs_q;
    vga_de_d       = vga_de_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    line_had_de_d  = line_had_de_q;
    line_width_d   = line_width_q;
    frame_height_d = frame_height_q;
    frame_cnt_d    = frame_cnt_q;
    frame_start_d  = 1'b0;
    audio_d        = widen_a(audio_in);
    if (ce_q) begin
      vga_r_d  = de_in ? expand_c(r_in) : 8'h00;
      vga_g_d  = de_in ? expand_c(g_in) : 8'h00;
      vga_b_d  = de_in ? expand_c(b_in) : 8'h00;
      vga_hs_d = hs_in;
      vga_vs_d = vs_in;
      vga_de_d = de_in;
      if (de_in) begin
        pix_x_d       = x_cnt_q;
        pix_y_d       = y_cnt_q;
        if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + 12'd1;
        line_had_de_d = 1'b1;
      end
      if (hs_edge) begin
        if (x_cnt_d != 12'd0) line_width_d = x_cnt_d;
        if (line_had_de_d && y_cnt_d != CNT_MAX) y_cnt_d = y_cnt_d + 12'd1;
        x_cnt_d       = 12'd0;
        line_had_de_d = 1'b0;
      end
      if (vs_edge) begin
        if (y_cnt_d != 12'd0) frame_height_d = y_cnt_d;
        y_cnt_d       = 12'd0;
        frame_cnt_d   = frame_cnt_q + 16'd1;
        frame_start_d = 1'b1;
      end
    end
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      ref_q          <= 1'b0;
      div_q          <= 4'd0;
      ce_q           <= 1'b0;
      vga_r_q        <= 8'h00;
      vga_g_q        <= 8'h00;
      vga_b_q        <= 8'h00;
      vga_hs_q       <= 1'b0;
      vga_vs_q       <= 1'b0;
      vga_de_q       <= 1'b0;
      pix_x_q        <= 12'd0;
      pix_y_q        <= 12'd0;
      x_cnt_q        <= 12'd0;
      y_cnt_q        <= 12'd0;
      line_had_de_q  <= 1'b0;
      line_width_q   <= 12'd0;
      frame_height_q <= 12'd0;
      frame_cnt_q    <= 16'd0;
      frame_start_q  <= 1'b0;
      audio_q        <= 16'd0;
    end else begin
      ref_q          <= ref_d;
      div_q          <= div_d;
      ce_q           <= ce_d;
      vga_r_q        <= vga_r_d;
      vga_g_q        <= vga_g_d;
      vga_b_q        <= vga_b_d;
      vga_hs_q       <= vga_hs_d;
      vga_vs_q       <= vga_vs_d;
      vga_de_q       <= vga_de_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      line_had_de_q  <= line_had_de_d;
      line_width_q   <= line_width_d;
      frame_height_q <= frame_height_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_start_q  <= frame_start_d;
      audio_q        <= audio_d;
    end
  end

  assign ce_pix       = ce_q;
  assign vga_r        = vga_r_q;
  assign vga_g        = vga_g_q;
  assign vga_b        = vga_b_q;
  assign vga_hs       = vga_hs_q;
  assign vga_vs       = vga_vs_q;
  assign vga_de       = vga_de_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign frame_cnt    = frame_cnt_q;
  assign frame_start  = frame_start_q;
  assign line_width   = line_width_q;
  assign frame_height = frame_height_q;
  assign audio_out    = audio_q;

endmodule

// File: tb/tb_sim_av_out.sv
// Bench for sim_av_out: three instances cover the internal divider (/4 and
// /2), the external reference mode, 4/6/8-bit colour and 8/12-bit audio.
module tb_sim_av_out;

  logic clk, reset, clk_ref;
  logic hs, vs, de;
  logic [5:0]  r0, g0, b0;
  logic [7:0]  r1, g1, b1;
  logic [3:0]  r2, g2, b2;
  logic [7:0]  aud0, aud1;
  logic [11:0] aud2;

  logic        ce0, ce1, ce2;
  logic [7:0]  vr0, vg0, vb0, vr1, vg1, vb1, vr2, vg2, vb2;
  logic        vhs0, vvs0, vde0, vhs1, vvs1, vde1, vhs2, vvs2, vde2;
  logic [11:0] px0, py0, px1, py1, px2, py2;
  logic [15:0] fc0, fc1, fc2;
  logic        fs0, fs1, fs2;
  logic [11:0] lw0, fh0, lw1, fh1, lw2, fh2;
  logic [15:0] ao0, ao1, ao2;

  sim_av_out #(.COLOR_BITS(6), .AUDIO_BITS(8), .AUDIO_SIGNED(0), .CE_EXT(0), .CE_DIV(4), .SYNC_POL(0)) u0 (
    .clk_48(clk), .reset(reset), .clk_ref(clk_ref), .r_in(r0), .g_in(g0), .b_in(b0),
    .hs_in(hs), .vs_in(vs), .de_in(de), .audio_in(aud0), .ce_pix(ce0),
    .vga_r(vr0), .vga_g(vg0), .vga_b(vb0), .vga_hs(vhs0), .vga_vs(vvs0), .vga_de(vde0),
    .pix_x(px0), .pix_y(py0), .frame_cnt(fc0), .frame_start(fs0),
    .line_width(lw0), .frame_height(fh0), .audio_out(ao0));

  sim_av_out #(.COLOR_BITS(8), .AUDIO_BITS(8), .AUDIO_SIGNED(1), .CE_EXT(1), .CE_DIV(4), .SYNC_POL(0)) u1 (
    .clk_48(clk), .reset(reset), .clk_ref(clk_ref), .r_in(r1), .g_in(g1), .b_in(b1),
    .hs_in(hs), .vs_in(vs), .de_in(de), .audio_in(aud1), .ce_pix(ce1),
    .vga_r(vr1), .vga_g(vg1), .vga_b(vb1), .vga_hs(vhs1), .vga_vs(vvs1), .vga_de(vde1),
    .pix_x(px1), .pix_y(py1), .frame_cnt(fc1), .frame_start(fs1),
    .line_width(lw1), .frame_height(fh1), .audio_out(ao1));

  sim_av_out #(.COLOR_BITS(4), .AUDIO_BITS(12), .AUDIO_SIGNED(0), .CE_EXT(0), .CE_DIV(2), .SYNC_POL(0)) u2 (
    .clk_48(clk), .reset(reset), .clk_ref(clk_ref), .r_in(r2), .g_in(g2), .b_in(b2),
    .hs_in(hs), .vs_in(vs), .de_in(de), .audio_in(aud2), .ce_pix(ce2),
    .vga_r(vr2), .vga_g(vg2), .vga_b(vb2), .vga_hs(vhs2), .vga_vs(vvs2), .vga_de(vde2),
    .pix_x(px2), .pix_y(py2), .frame_cnt(fc2), .frame_start(fs2),
    .line_width(lw2), .frame_height(fh2), .audio_out(ao2));

  int n_checks = 0;
  int n_pass   = 0;

  // frame_start monitor
  logic mon_en = 1'b0;
  int   fs_cycles = 0;
  int   fs_consec = 0;
  logic fs_last = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk_ref: high during [20,40), [60,80), ... ns, i.e. a 4-cycle period
  initial begin
    clk_ref = 1'b0;
    forever begin
      @(negedge clk);
      @(negedge clk);
      clk_ref = ~clk_ref;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (fs0) begin
        fs_cycles++;
        if (fs_last) fs_consec++;
      end
      fs_last = fs0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Hold current inputs until u0 takes a ce_pix sample, then return on the
  // negedge where that sample's results are visible.
  task automatic pix0();
    int n;
    n = 0;
    while (!ce0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ce0) chk("ce0_timeout", 32'(ce0), 32'd1);
    @(negedge clk);
  endtask

  // Frame: 12 lines of 24 pixels, 16 de pixels on lines 0..9, hs low on
  // pixels 19-20, vs low on line 10. Frame 1 starts vs together with the
  // hs edge of line 9.
  task automatic drive_px(input int f, input int line, input int px);
    de = (line < 10) && (px < 16);
    hs = !(px == 19 || px == 20);
    vs = !((line == 10) || (f == 1 && line == 9 && px >= 19));
    r0 = 6'(px);
    pix0();
  endtask

  typedef struct {
    logic [5:0]  r, g, b;
    logic        de;
    logic [7:0]  aud;
    logic [7:0]  er, eg, eb;
    logic [15:0] eau, eas;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int mis1, mis2, cnt1, cnt_rst;
    vecs[0] = '{6'h2A, 6'h3F, 6'h00, 1'b1, 8'h80, 8'hAA, 8'hFF, 8'h00, 16'h8080, 16'h8000};
    vecs[1] = '{6'h3F, 6'h01, 6'h20, 1'b1, 8'hFF, 8'hFF, 8'h04, 8'h82, 16'hFFFF, 16'hFF00};
    vecs[2] = '{6'h2A, 6'h3F, 6'h15, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 16'h0101, 16'h0100};
    vecs[3] = '{6'h15, 6'h2A, 6'h3E, 1'b1, 8'h7F, 8'h55, 8'hAA, 8'hFB, 16'h7F7F, 16'h7F00};

    reset = 1'b1;
    hs = 1'b1; vs = 1'b1; de = 1'b0;
    r0 = '0; g0 = '0; b0 = '0; r1 = '0; g1 = '0; b1 = '0; r2 = '0; g2 = '0; b2 = '0;
    aud0 = '0; aud1 = '0; aud2 = '0;

    // reset held 6 cycles; clk_ref falls during it
    cnt_rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ce0 || ce1 || ce2) cnt_rst++;
    end
    chk("ce_during_reset", 32'(cnt_rst), 32'd0);
    chk("rst_vga_r", 32'(vr0), 32'd0);
    chk("rst_vga_hs", 32'(vhs0), 32'd0);
    chk("rst_pix_x", 32'(px0), 32'd0);
    chk("rst_frame_cnt", 32'(fc0), 32'd0);
    chk("rst_line_width", 32'(lw0), 32'd0);
    chk("rst_frame_height", 32'(fh0), 32'd0);
    chk("rst_audio", 32'(ao0), 32'd0);

    // released at t=60ns; k counts clk_48 edges after release
    reset = 1'b0;
    mis1 = 0; mis2 = 0; cnt1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 12) chk($sformatf("ce_div4_k%0d", k), 32'(ce0), 32'((k % 4) == 0));
      if (ce2 != ((k % 2) == 0)) mis2++;
      if (ce1 != ((k % 4) == 3)) mis1++;
      if (ce1) cnt1++;
    end
    chk("ce_div2_pattern_mismatches", 32'(mis2), 32'd0);
    chk("ce_ext_pattern_mismatches", 32'(mis1), 32'd0);
    chk("ce_ext_count", 32'(cnt1), 32'd10);

    // colour / audio vectors
    for (int v = 0; v < 4; v++) begin
      r0 = vecs[v].r; g0 = vecs[v].g; b0 = vecs[v].b; de = vecs[v].de;
      aud0 = vecs[v].aud; aud1 = vecs[v].aud;
      pix0();
      chk($sformatf("vec%0d_vga_r", v), 32'(vr0), 32'(vecs[v].er));
      chk($sformatf("vec%0d_vga_g", v), 32'(vg0), 32'(vecs[v].eg));
      chk($sformatf("vec%0d_vga_b", v), 32'(vb0), 32'(vecs[v].eb));
      chk($sformatf("vec%0d_vga_de", v), 32'(vde0), 32'(vecs[v].de));
      chk($sformatf("vec%0d_audio_u", v), 32'(ao0), 32'(vecs[v].eau));
      chk($sformatf("vec%0d_audio_s", v), 32'(ao1), 32'(vecs[v].eas));
    end

    // outputs hold between ce_pix samples
    r0 = 6'h01;
    @(negedge clk);
    chk("hold_between_ce", 32'(vr0), 32'h55);

    // 8-bit passthrough, 4-bit colour, 12-bit audio
    de = 1'b1; r1 = 8'h5C; r2 = 4'hA; aud2 = 12'hABC;
    repeat (6) @(negedge clk);
    chk("c8_passthrough", 32'(vr1), 32'h5C);
    chk("c4_expand", 32'(vr2), 32'hAA);
    chk("audio12_abc", 32'(ao2), 32'hABCA);
    aud2 = 12'h123;
    @(negedge clk);
    chk("audio12_latency1", 32'(ao2), 32'h1231);

    // geometry: two frames after a clean reset
    de = 1'b0; hs = 1'b1; vs = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int line = 0; line < 12; line++) begin
        for (int px = 0; px < 24; px++) begin
          drive_px(f, line, px);
          if (f == 0 && line == 9 && px == 15) begin
            chk("last_pix_x", 32'(px0), 32'd15);
            chk("last_pix_y", 32'(py0), 32'd9);
          end
          if (f == 1 && line == 9 && px == 19) begin
            chk("coincident_frame_height", 32'(fh0), 32'd10);
            chk("coincident_frame_cnt", 32'(fc0), 32'd2);
          end
        end
      end
      if (f == 0) begin
        chk("f0_frame_cnt", 32'(fc0), 32'd1);
        chk("f0_frame_height", 32'(fh0), 32'd10);
        chk("f0_line_width", 32'(lw0), 32'd16);
      end
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("frame_start_cycles", 32'(fs_cycles), 32'd2);
    chk("frame_start_multi_cycle", 32'(fs_consec), 32'd0);

    // reset in the middle of line 5, then finish that frame and run another
    for (int f = 2; f < 4; f++) begin
      for (int line = 0; line < 12; line++) begin
        for (int px = 0; px < 24; px++) begin
          if (f == 2 && line == 5 && px == 8) begin
            reset = 1'b1;
            @(negedge clk);
            chk("midrst_ce", 32'(ce0), 32'd0);
            chk("midrst_vga_r", 32'(vr0), 32'd0);
            chk("midrst_vga_de", 32'(vde0), 32'd0);
            chk("midrst_pix_x", 32'(px0), 32'd0);
            chk("midrst_pix_y", 32'(py0), 32'd0);
            chk("midrst_frame_cnt", 32'(fc0), 32'd0);
            chk("midrst_frame_height", 32'(fh0), 32'd0);
            chk("midrst_line_width", 32'(lw0), 32'd0);
            chk("midrst_audio", 32'(ao0), 32'd0);
            reset = 1'b0;
          end
          drive_px(f, line, px);
          if (f == 2 && line == 5 && px == 22) chk("midrst_partial_width", 32'(lw0), 32'd8);
        end
      end
      if (f == 2) begin
        chk("partial_frame_cnt", 32'(fc0), 32'd1);
        chk("partial_frame_height", 32'(fh0), 32'd5);
      end else begin
        chk("rerun_frame_cnt", 32'(fc0), 32'd2);
        chk("rerun_frame_height", 32'(fh0), 32'd10);
        chk("rerun_line_width", 32'(lw0), 32'd16);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
